// File: rtl/iob_burst_bridge.sv
// ---------------------------------------------------------------------------
// iob_burst_bridge
//
// Converts a single-command burst request into a sequence of native
// single-beat memory transactions. A read command of len+1 beats becomes
// len+1 back-to-back native reads. Each returned word is forwarded one
// cycle later on the rsp_* port. A write command is always one native beat.
//
// Parameters
//   ADDR_W   : address width
//   DATA_W   : data width (BYTES = DATA_W/8 byte lanes)
//   BURST_W  : burst length field width, max 2^BURST_W beats
//   WRAP     : 1 = wrapping read bursts (critical word first),
//              0 = incrementing
//   REMAP_EN : 1 = force the address MSB high while boot is low
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   boot              : boot status, sampled at command acceptance
//   cmd_valid/ready   : command handshake; ready only while idle
//   cmd_wr            : 1 = write, 0 = read
//   cmd_addr          : byte start address (low lane bits ignored)
//   cmd_len           : beats minus one (reads only)
//   cmd_wdata/wstrb   : write data / byte strobes
//   rsp_valid/data    : read beat returned to the consumer (no backpressure)
//   rsp_last          : marks the final beat of a read burst
//   mem_valid/addr    : native request, held until mem_ready
//   mem_wdata/wstrb   : native write data / strobes (strobes zero on reads)
//   mem_ready/rdata   : native completion, read data valid in that cycle
//
// Assumes ADDR_W >= log2(BYTES) + BURST_W so that the wrap index field
// lies inside the address.
// ---------------------------------------------------------------------------
module iob_burst_bridge #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int BURST_W  = 3,
  parameter int WRAP     = 0,
  parameter int REMAP_EN = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [BURST_W-1:0]    cmd_len,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_last,
  output logic                  mem_valid,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;

  // Clears the byte-lane offset bits of an address.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_reg, state_next;

  // Burst context captured at acceptance.
  logic [ADDR_W-1:0]  base_reg;
  logic [BURST_W-1:0] len_reg;
  logic [BURST_W-1:0] cnt_reg;
  logic               wr_reg;
  logic               boot_reg;

  // Registered outputs.
  logic                mem_valid_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [BYTES-1:0]    mem_wstrb_reg;
  logic                rsp_valid_reg;
  logic [DATA_W-1:0]   rsp_data_reg;
  logic                rsp_last_reg;

  logic               accept;
  logic               beat_done;
  logic               last_beat;
  logic [BURST_W-1:0] cnt_inc;
  logic [ADDR_W-1:0]  cmd_base;
  logic [BURST_W-1:0] cmd_len_eff;

  // -------------------------------------------------------------------------
  // Address of beat number cnt within a burst.
  // Incrementing: base + cnt*BYTES, wrapping modulo 2^ADDR_W.
  // Wrapping: only the word-index field is replaced. It becomes
  // (start_idx + cnt) & len, so a power-of-two burst walks around its
  // aligned block. The bits above the field are held from base.
  // Remap is applied last: while boot was low at acceptance, the MSB is
  // forced high.
  // -------------------------------------------------------------------------
  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [ADDR_W-1:0]  base,
    input logic [BURST_W-1:0] len,
    input logic [BURST_W-1:0] cnt,
    input logic               boot_v
  );
    logic [ADDR_W-1:0]  a;
    logic [BURST_W-1:0] idx;
    if (WRAP != 0) begin
      idx = (base[OFF_W +: BURST_W] + cnt) & len;
      a = base;
      a[OFF_W +: BURST_W] = idx;
    end else begin
      idx = len & cnt;  // keeps the argument list uniform across modes
      a = base + (ADDR_W'(cnt) << OFF_W);
    end
    a[ADDR_W-1] = a[ADDR_W-1] | ((REMAP_EN != 0) & ~boot_v);
    return a;
  endfunction

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  assign accept      = cmd_valid & cmd_ready;
  // A completion is only meaningful while a request is outstanding.
  assign beat_done   = (state_reg == BUSY) & mem_valid_reg & mem_ready;
  assign last_beat   = (cnt_reg == len_reg);
  assign cnt_inc     = cnt_reg + BURST_W'(1);
  assign cmd_base    = cmd_addr & ALIGN_MASK;
  assign cmd_len_eff = cmd_wr ? '0 : cmd_len;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // The return to IDLE takes effect after the final completion, so a new
  // command can never be accepted in the same cycle as that completion.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (cmd_valid) state_next = BUSY;
      BUSY: if (beat_done && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    if (state_reg == IDLE) cmd_ready = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Burst context and native request registers
  // The first beat address is computed from the command inputs, so
  // mem_valid rises in the cycle after acceptance. Later beat addresses
  // come from the captured context. The address of beat cnt+1 is computed
  // as beat cnt completes, which keeps beats back-to-back.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      base_reg      <= '0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      wr_reg        <= 1'b0;
      boot_reg      <= 1'b0;
      mem_valid_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
    end else if (accept) begin
      base_reg      <= cmd_base;
      len_reg       <= cmd_len_eff;
      cnt_reg       <= '0;
      wr_reg        <= cmd_wr;
      boot_reg      <= boot;
      mem_valid_reg <= 1'b1;
      mem_addr_reg  <= beat_addr(cmd_base, cmd_len_eff, '0, boot);
      mem_wdata_reg <= cmd_wdata;
      mem_wstrb_reg <= cmd_wr ? cmd_wstrb : '0;
    end else if (beat_done) begin
      if (last_beat) begin
        mem_valid_reg <= 1'b0;
        cnt_reg       <= '0;
      end else begin
        cnt_reg      <= cnt_inc;
        mem_addr_reg <= beat_addr(base_reg, len_reg, cnt_inc, boot_reg);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read response path: one registered beat per read completion
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_last_reg  <= 1'b0;
    end else begin
      rsp_valid_reg <= beat_done & ~wr_reg;
      rsp_last_reg  <= beat_done & ~wr_reg & last_beat;
      if (beat_done && !wr_reg) begin
        rsp_data_reg <= mem_rdata;
      end
    end
  end

  assign mem_valid = mem_valid_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_last  = rsp_last_reg;

endmodule

// File: tb/tb_iob_burst_bridge.sv
// ---------------------------------------------------------------------------
// tb_iob_burst_bridge
//
// Directed bench for iob_burst_bridge. Three instances share one stimulus
// stream and run in lock-step, because beat timing does not depend on the
// parameters:
//   u_inc   : WRAP=0, REMAP_EN=0
//   u_wrap  : WRAP=1, REMAP_EN=0
//   u_remap : WRAP=0, REMAP_EN=1
// Inputs change and outputs are checked 1 ns after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_iob_burst_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot;
  logic        cmd_valid;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        a_cmd_ready, a_rsp_valid, a_rsp_last, a_mem_valid;
  logic [31:0] a_rsp_data, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wstrb;
  logic        b_cmd_ready, b_rsp_valid, b_rsp_last, b_mem_valid;
  logic [31:0] b_rsp_data, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wstrb;
  logic        c_cmd_ready, c_rsp_valid, c_rsp_last, c_mem_valid;
  logic [31:0] c_rsp_data, c_mem_addr, c_mem_wdata;
  logic [3:0]  c_mem_wstrb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  iob_burst_bridge #(.ADDR_W(32), .DATA_W(32), .BURST_W(3), .WRAP(0), .REMAP_EN(0)) u_inc (
    .clk(clk), .rst(rst), .boot(boot),
    .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_last(a_rsp_last),
    .mem_valid(a_mem_valid), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wstrb(a_mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  iob_burst_bridge #(.ADDR_W(32), .DATA_W(32), .BURST_W(3), .WRAP(1), .REMAP_EN(0)) u_wrap (
    .clk(clk), .rst(rst), .boot(boot),
    .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_last(b_rsp_last),
    .mem_valid(b_mem_valid), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  iob_burst_bridge #(.ADDR_W(32), .DATA_W(32), .BURST_W(3), .WRAP(0), .REMAP_EN(1)) u_remap (
    .clk(clk), .rst(rst), .boot(boot),
    .cmd_valid(cmd_valid), .cmd_ready(c_cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(c_rsp_valid), .rsp_data(c_rsp_data), .rsp_last(c_rsp_last),
    .mem_valid(c_mem_valid), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
    .mem_wstrb(c_mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Hand-computed wrap sequences.
  logic [31:0] wrap8_exp [8] = '{32'h118, 32'h11C, 32'h100, 32'h104,
                                 32'h108, 32'h10C, 32'h110, 32'h114};
  logic [31:0] wrap4_exp [4] = '{32'h10C, 32'h100, 32'h104, 32'h108};

  initial begin
    rst = 1'b1; boot = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0;
    cmd_addr = '0; cmd_len = '0; cmd_wdata = '0; cmd_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;

    // ---------------- reset state ----------------
    $display("txn reset");
    chk("rst_cmd_ready", a_cmd_ready, 1);
    chk("rst_mem_valid", a_mem_valid, 0);
    chk("rst_mem_addr",  a_mem_addr, 0);
    chk("rst_mem_wdata", a_mem_wdata, 0);
    chk("rst_mem_wstrb", a_mem_wstrb, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rsp_data",  a_rsp_data, 0);
    chk("rst_rsp_last",  a_rsp_last, 0);

    // A stray mem_ready while idle must be ignored.
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("idle_ready_rsp_valid", a_rsp_valid, 0);
    chk("idle_ready_mem_valid", a_mem_valid, 0);

    // ---------------- single read ----------------
    $display("txn read addr=0x100 len=0");
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h100; cmd_len = 3'd0;
    cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    chk("rd1_mem_valid", a_mem_valid, 1);
    chk("rd1_mem_addr",  a_mem_addr, 32'h100);
    chk("rd1_mem_wstrb", a_mem_wstrb, 0);
    chk("rd1_cmd_ready", a_cmd_ready, 0);
    tick();
    chk("rd1_hold_valid", a_mem_valid, 1);
    chk("rd1_hold_addr",  a_mem_addr, 32'h100);
    mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick();
    mem_ready = 1'b0;
    chk("rd1_rsp_valid", a_rsp_valid, 1);
    chk("rd1_rsp_data",  a_rsp_data, 32'hA5A5A5A5);
    chk("rd1_rsp_last",  a_rsp_last, 1);
    chk("rd1_mem_valid_off", a_mem_valid, 0);
    chk("rd1_cmd_ready_back", a_cmd_ready, 1);
    tick();
    chk("rd1_rsp_valid_off", a_rsp_valid, 0);

    // ---------------- incrementing burst ----------------
    $display("txn read incr addr=0x1F8 len=7");
    cmd_valid = 1'b1; cmd_addr = 32'h1F8; cmd_len = 3'd7;
    tick();
    cmd_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("inc_mem_valid", a_mem_valid, 1);
      chk("inc_mem_addr", a_mem_addr, 32'h1F8 + 32'(4 * i));
      mem_rdata = 32'hD000_0000 | 32'(i);
      tick();
      chk("inc_rsp_valid", a_rsp_valid, 1);
      chk("inc_rsp_data", a_rsp_data, 32'hD000_0000 | 32'(i));
      chk("inc_rsp_last", a_rsp_last, (i == 7) ? 32'd1 : 32'd0);
    end
    mem_ready = 1'b0;
    chk("inc_end_mem_valid", a_mem_valid, 0);
    chk("inc_end_cmd_ready", a_cmd_ready, 1);
    tick();
    chk("inc_end_rsp_valid", a_rsp_valid, 0);

    // ---------------- wrapping burst, 8 beats ----------------
    $display("txn read wrap addr=0x118 len=7");
    cmd_valid = 1'b1; cmd_addr = 32'h118; cmd_len = 3'd7;
    tick();
    cmd_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("wrap8_mem_addr", b_mem_addr, wrap8_exp[i]);
      mem_rdata = 32'hB000_0000 | 32'(i);
      tick();
      chk("wrap8_rsp_data", b_rsp_data, 32'hB000_0000 | 32'(i));
      chk("wrap8_rsp_last", b_rsp_last, (i == 7) ? 32'd1 : 32'd0);
    end
    mem_ready = 1'b0;
    chk("wrap8_end_mem_valid", b_mem_valid, 0);
    tick();

    // ---------------- wrapping burst, 4 beats ----------------
    $display("txn read wrap addr=0x10C len=3");
    cmd_valid = 1'b1; cmd_addr = 32'h10C; cmd_len = 3'd3;
    tick();
    cmd_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap4_mem_addr", b_mem_addr, wrap4_exp[i]);
      tick();
      chk("wrap4_rsp_last", b_rsp_last, (i == 3) ? 32'd1 : 32'd0);
    end
    mem_ready = 1'b0;
    chk("wrap4_end_mem_valid", b_mem_valid, 0);
    tick();

    // ---------------- write with stalls ----------------
    $display("txn write addr=0x203 data=0x12345678 strb=0x3 len=5");
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h203; cmd_len = 3'd5;
    cmd_wdata = 32'h12345678; cmd_wstrb = 4'h3;
    tick();
    cmd_valid = 1'b0; cmd_wr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("wr_mem_valid", a_mem_valid, 1);
      chk("wr_mem_addr",  a_mem_addr, 32'h200);
      chk("wr_mem_wdata", a_mem_wdata, 32'h12345678);
      chk("wr_mem_wstrb", a_mem_wstrb, 4'h3);
      chk("wr_rsp_valid", a_rsp_valid, 0);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("wr_done_mem_valid", a_mem_valid, 0);
    chk("wr_done_rsp_valid", a_rsp_valid, 0);
    chk("wr_done_cmd_ready", a_cmd_ready, 1);
    tick();
    chk("wr_single_mem_valid", a_mem_valid, 0);
    chk("wr_single_rsp_valid", a_rsp_valid, 0);

    // ---------------- remap ----------------
    $display("txn read remap addr=0x40 len=3 boot=0");
    boot = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_len = 3'd3;
    tick();
    cmd_valid = 1'b0;
    chk("remap_beat0_addr", c_mem_addr, 32'h8000_0040);
    chk("noremap_beat0_addr", a_mem_addr, 32'h0000_0040);
    mem_ready = 1'b1;
    tick();
    boot = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk("remap_beat_addr", c_mem_addr, 32'h8000_0040 + 32'(4 * i));
      tick();
    end
    mem_ready = 1'b0;
    chk("remap_rsp_last", c_rsp_last, 1);
    chk("remap_end_mem_valid", c_mem_valid, 0);
    tick();

    // ---------------- reset abort ----------------
    $display("txn read addr=0x300 len=7 aborted by reset");
    cmd_valid = 1'b1; cmd_addr = 32'h300; cmd_len = 3'd7;
    tick();
    cmd_valid = 1'b0;
    mem_ready = 1'b1;
    tick(); tick(); tick();
    chk("abort_beat3_addr", a_mem_addr, 32'h30C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_ready = 1'b0;
    chk("abort_mem_valid", a_mem_valid, 0);
    chk("abort_rsp_valid", a_rsp_valid, 0);
    chk("abort_cmd_ready", a_cmd_ready, 1);
    chk("abort_mem_addr",  a_mem_addr, 0);
    tick();
    chk("abort_after_mem_valid", a_mem_valid, 0);
    chk("abort_after_rsp_valid", a_rsp_valid, 0);

    $display("txn read addr=0x400 len=0 after abort");
    cmd_valid = 1'b1; cmd_addr = 32'h400; cmd_len = 3'd0;
    tick();
    cmd_valid = 1'b0;
    chk("post_abort_mem_valid", a_mem_valid, 1);
    chk("post_abort_mem_addr", a_mem_addr, 32'h400);
    mem_ready = 1'b1; mem_rdata = 32'h5A5A1234;
    tick();
    mem_ready = 1'b0;
    chk("post_abort_rsp_valid", a_rsp_valid, 1);
    chk("post_abort_rsp_data", a_rsp_data, 32'h5A5A1234);
    chk("post_abort_rsp_last", a_rsp_last, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iob_burst_bridge.md
IOB_BURST_BRIDGE -- requirements
Module: iob_burst_bridge

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; BYTES=DATA_W/8.
- BURST_W, 3, burst length field width; max beats 2^BURST_W.
- WRAP, 0, 1 = wrapping read bursts (critical word first), 0 = incrementing.
- REMAP_EN, 0, 1 = external-memory address remap by boot.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk  in  1  clock; the block has one clock.
- rst  in  1  reset; synchronous, active-high.
- boot  in  1  boot status, used when REMAP_EN=1.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_wr  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte start address.
- cmd_len  in  BURST_W  beats minus one; reads only.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  BYTES  write byte strobes.
- rsp_valid  out  1  read beat valid; the consumer always accepts it.
- rsp_data  out  DATA_W  read beat data.
- rsp_last  out  1  final beat of the burst.
- mem_valid  out  1  native request.
- mem_addr  out  ADDR_W  native address.
- mem_wdata  out  DATA_W  native write data.
- mem_wstrb  out  BYTES  native strobes; all zero on reads.
- mem_ready  in  1  native completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  native read data.

Function
REQ-003 The FSM SHALL have states IDLE and BUSY; cmd_ready=1 only in IDLE.
REQ-004 On cmd_valid&cmd_ready the block SHALL go to BUSY and register the following:
- address, with its low log2(BYTES) bits forced to 0;
- len, where writes force len=0;
- wr, wdata, wstrb;
- boot.
REQ-005 All mem_* outputs SHALL be registered; mem_valid SHALL rise the cycle after acceptance.
REQ-006 While BUSY, mem_valid SHALL stay 1 and mem_addr, mem_wdata and mem_wstrb SHALL stay stable until mem_ready.
REQ-007 The beat counter cnt SHALL start at 0 and increment on each mem_ready in BUSY.
REQ-008 When cnt<len at mem_ready, the next beat's address SHALL be presented the following cycle with mem_valid kept high; beats SHALL run back-to-back with no idle cycle.
REQ-009 Beat address with WRAP=0: base + cnt*BYTES, modulo 2^ADDR_W.
REQ-010 Beat address with WRAP=1:
- word-index bits [log2(BYTES)+BURST_W-1 : log2(BYTES)] = (start_idx + cnt) & len;
- upper bits are held from base;
- len+1 SHALL be a power of two; any other value is illegal and unchecked.
REQ-011 When cnt==len at mem_ready, the block SHALL return to IDLE: mem_valid=0 and cmd_ready=1 from the next cycle. A command is never accepted in that same mem_ready cycle.
REQ-012 Each read mem_ready SHALL produce rsp_valid=1 exactly one cycle later, with:
- rsp_data = the registered mem_rdata;
- rsp_last = 1 only for beat cnt==len.
REQ-013 Writes SHALL produce no rsp_valid; the write completes when mem_ready is seen.
REQ-014 mem_ready while mem_valid=0 SHALL be ignored.
REQ-015 With REMAP_EN=1, mem_addr[ADDR_W-1] SHALL equal registered_addr[ADDR_W-1] | ~registered_boot. A boot change mid-burst SHALL NOT affect the remaining beats.
REQ-016 With REMAP_EN=0, mem_addr[ADDR_W-1] SHALL pass through unchanged.
REQ-017 cmd_len values SHALL always be interpreted modulo 2^BURST_W; a burst never exceeds 2^BURST_W beats.

Reset
REQ-018 While rst=1 at a clk edge, the following SHALL hold on the next cycle:
- state=IDLE, cnt=0;
- mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0;
- rsp_valid=0, rsp_data=0, rsp_last=0;
- cmd_ready=1.
REQ-019 Reset mid-burst SHALL abort the burst: no further mem_valid and no rsp_valid, including for a mem_ready coincident with rst.

Verification
REQ-020 Single read: cmd addr=0x100, len=0, mem_ready one cycle after mem_valid, rdata=0xA5A5A5A5 -> one beat at mem_addr=0x100, rsp_valid with data 0xA5A5A5A5, rsp_last=1, cmd_ready back high.
REQ-021 Incrementing burst: WRAP=0, addr=0x1F8, len=7, mem_ready held high -> mem_addr sequence 0x1F8, 0x1FC … 0x214 on consecutive cycles, 8 rsp beats in order, rsp_last only on the 8th.
REQ-022 Wrapping burst: WRAP=1, addr=0x118, len=7 -> mem_addr sequence 0x118, 0x11C, 0x100 … 0x114; rsp_last on addr 0x114.
REQ-023 Write with stalls: cmd_wr=1, addr=0x203 (forced to 0x200), wdata=0x12345678, wstrb=0x3, len=5 (forced to 0), mem_ready delayed 4 cycles -> mem_valid, addr, data and strobes stable for 4 cycles, a single beat, no rsp_valid.
REQ-024 Remap: REMAP_EN=1, boot=0, read addr=0x0000_0040 -> mem_addr=0x8000_0040; boot toggled to 1 mid-burst -> MSB stays 1 for the remaining beats.
REQ-025 Reset abort: rst asserted at beat 3 of a len=7 read -> mem_valid=0 and rsp_valid=0 next cycle, cmd_ready=1, and a new command is accepted normally.
